dac_stream: RTL and testbench

Transmit-side audio streamer for the WM8731 CODEC DAC path. It accepts mono N-bit samples from the processing chain over a valid/ready handshake and buffers them in a small FIFO. It serialises each sample MSB-first onto DACDAT in left-justified format, framed by the CODEC-driven DACLRC, with the same sample sent on both channels. It is the outbound counterpart of the microphone capture path and shares its BCLK domain; the CODEC is I2C-configured as master for LJ, N-bit, MSB-first.

---
 rtl/audio_pkg.sv | 22 ++
 rtl/sample_fifo.sv | 73 +++++++
 rtl/dac_stream.sv | 135 +++++++++++++
 tb/tb_dac_stream.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// ----------------------------------------------------------------------------
// audio_pkg
// Shared definitions for the audio streaming blocks: default sample width and
// FIFO depth, the DAC serialiser state type and the underrun counter ceiling.
// No ports.
// ----------------------------------------------------------------------------
package audio_pkg;

    localparam int N_DEFAULT          = 16;
    localparam int FIFO_DEPTH_DEFAULT = 4;

    localparam logic [15:0] UNDERRUN_MAX = 16'hFFFF;

    typedef enum logic [2:0] {
        WAIT_FRAME = 3'd0,
        SHIFT_L    = 3'd1,
        PAD_L      = 3'd2,
        SHIFT_R    = 3'd3,
        PAD_R      = 3'd4
    } dac_state_t;

endpackage

// File: rtl/sample_fifo.sv
// ----------------------------------------------------------------------------
// sample_fifo
// Small synchronous FIFO holding PCM samples between the processing chain and
// the DAC serialiser. Push and pop in the same cycle are both honoured.
// Ports:
//   clk        in   clock
//   reset      in   synchronous active-high reset, discards contents
//   push       in   write push_data (ignored when full)
//   push_data  in   W-bit sample to store
//   pop        in   advance read pointer (ignored when empty)
//   pop_data   out  oldest stored sample (valid when not empty)
//   full       out  level == DEPTH
//   empty      out  level == 0
//   level      out  current occupancy
// ----------------------------------------------------------------------------
module sample_fifo #(
    parameter  int W     = 16,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  pop_data,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Depth is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset; pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/dac_stream.sv
// ----------------------------------------------------------------------------
// dac_stream
// Transmit-side streamer for the WM8731 DAC path. Buffers mono samples in a
// FIFO and shifts each one out MSB-first, left-justified, on both channels of
// the CODEC-driven DACLRC frame.
// Ports:
//   bclk            in   CODEC bit clock, sole clock
//   reset           in   synchronous active-high reset
//   sample_valid    in   upstream sample present
//   sample_data     in   N-bit signed PCM sample
//   sample_ready    out  FIFO can accept this cycle
//   daclrc          in   frame clock, high = left, low = right
//   dacdat          out  serial data to CODEC
//   underrun        out  one-cycle pulse when a left frame starts empty
//   underrun_count  out  saturating underrun count
//   fifo_level      out  FIFO occupancy
// ----------------------------------------------------------------------------
module dac_stream
    import audio_pkg::*;
#(
    parameter int N          = N_DEFAULT,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic                          bclk,
    input  logic                          reset,
    input  logic                          sample_valid,
    input  logic [N-1:0]                  sample_data,
    output logic                          sample_ready,
    input  logic                          daclrc,
    output logic                          dacdat,
    output logic                          underrun,
    output logic [15:0]                   underrun_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int                BIT_W    = $clog2(N);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(N - 1);

    dac_state_t        state;
    logic [BIT_W-1:0]  bit_index;
    logic [N-1:0]      shift_reg;
    logic [N-1:0]      hold_reg;
    logic              daclrc_q;
    logic              redge;
    logic              fedge;
    logic              fifo_full;
    logic              fifo_empty;
    logic [N-1:0]      fifo_data;
    logic              push;
    logic              pop;
    logic [N-1:0]      next_sample;

    assign redge = daclrc & ~daclrc_q;
    assign fedge = ~daclrc & daclrc_q;

    // Ready is forced low while reset is held so nothing is accepted then.
    assign sample_ready = !reset && !fifo_full;
    assign push         = sample_valid && sample_ready;
    assign pop          = redge && !fifo_empty;

    // No bypass path: an empty FIFO at a left-frame start sends silence even
    // if a sample is being pushed in the same cycle.
    assign next_sample  = fifo_empty ? '0 : fifo_data;

    sample_fifo #(
        .W     (N),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (bclk),
        .reset     (reset),
        .push      (push),
        .push_data (sample_data),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Serialiser. Frame edges take priority over shifting, so a frame shorter
    // than N bits simply drops the tail of the current sample.
    always_ff @(posedge bclk) begin
        if (reset) begin
            state     <= WAIT_FRAME;
            bit_index <= '0;
            shift_reg <= '0;
            hold_reg  <= '0;
            daclrc_q  <= 1'b1;
            dacdat    <= 1'b0;
            underrun  <= 1'b0;
            underrun_count <= '0;
        end else begin
            daclrc_q <= daclrc;
            underrun <= 1'b0;
            if (redge) begin
                hold_reg  <= next_sample;
                shift_reg <= next_sample;
                dacdat    <= next_sample[N-1];
                bit_index <= BIT_W'(1);
                state     <= SHIFT_L;
                if (fifo_empty) begin
                    underrun <= 1'b1;
                    if (underrun_count != UNDERRUN_MAX) begin
                        underrun_count <= underrun_count + 16'd1;
                    end
                end
            end else if (fedge && (state == SHIFT_L || state == PAD_L)) begin
                shift_reg <= hold_reg;
                dacdat    <= hold_reg[N-1];
                bit_index <= BIT_W'(1);
                state     <= SHIFT_R;
            end else begin
                case (state)
                    SHIFT_L, SHIFT_R: begin
                        dacdat <= shift_reg[LAST_BIT - bit_index];
                        if (bit_index == LAST_BIT) begin
                            bit_index <= '0;
                            state     <= (state == SHIFT_L) ? PAD_L : PAD_R;
                        end else begin
                            bit_index <= bit_index + BIT_W'(1);
                        end
                    end
                    WAIT_FRAME, PAD_L, PAD_R: begin
                        dacdat <= 1'b0;
                    end
                    default: begin
                        dacdat <= 1'b0;
                        state  <= WAIT_FRAME;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dac_stream.sv
// ----------------------------------------------------------------------------
// tb_dac_stream
// Directed bench for dac_stream with N=16, FIFO_DEPTH=4. Inputs are driven and
// outputs sampled 1 time unit after each rising bclk edge.
// ----------------------------------------------------------------------------
module tb_dac_stream;

    logic        bclk = 1'b0;
    logic        reset;
    logic        sample_valid;
    logic [15:0] sample_data;
    logic        sample_ready;
    logic        daclrc;
    logic        dacdat;
    logic        underrun;
    logic [15:0] underrun_count;
    logic [2:0]  fifo_level;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [15:0] queued [5];

    dac_stream #(
        .N          (16),
        .FIFO_DEPTH (4)
    ) dut (
        .bclk           (bclk),
        .reset          (reset),
        .sample_valid   (sample_valid),
        .sample_data    (sample_data),
        .sample_ready   (sample_ready),
        .daclrc         (daclrc),
        .dacdat         (dacdat),
        .underrun       (underrun),
        .underrun_count (underrun_count),
        .fifo_level     (fifo_level)
    );

    always #5 bclk = ~bclk;

    // One bclk cycle with the given frame level. A sample offered on
    // sample_valid is withdrawn once the handshake completes.
    task automatic applyStimulus(input logic lrc);
        logic hs;
        daclrc = lrc;
        #0;
        hs = sample_valid && sample_ready;
        @(posedge bclk);
        #1;
        if (hs) sample_valid = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_asserts++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Offer one sample and clock it in while the frame clock stays put.
    task automatic pushSample(input logic [15:0] value, input logic lrc);
        sample_valid = 1'b1;
        sample_data  = value;
        applyStimulus(lrc);
    endtask

    // A full frame: 'half' cycles high then 'half' low. Both halves must carry
    // the top min(half,16) bits of exp MSB-first, then zeros.
    task automatic runFrame(input int half, input logic [15:0] exp, input logic exp_ur);
        for (int i = 0; i < half; i++) begin
            applyStimulus(1'b1);
            checkOutput("left_bit", 32'(dacdat), (i < 16) ? 32'(exp[15-i]) : 32'd0);
            checkOutput("left_underrun", 32'(underrun), (i == 0) ? 32'(exp_ur) : 32'd0);
        end
        for (int i = 0; i < half; i++) begin
            applyStimulus(1'b0);
            checkOutput("right_bit", 32'(dacdat), (i < 16) ? 32'(exp[15-i]) : 32'd0);
            checkOutput("right_underrun", 32'(underrun), 32'd0);
        end
    endtask

    initial begin
        reset        = 1'b1;
        daclrc       = 1'b1;
        sample_valid = 1'b0;
        sample_data  = '0;

        // Reset with daclrc high, then release: no spurious frame start.
        $display("[TB] reset state");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1);
        checkOutput("rst_dacdat", 32'(dacdat), 32'd0);
        checkOutput("rst_ready", 32'(sample_ready), 32'd0);
        checkOutput("rst_level", 32'(fifo_level), 32'd0);
        checkOutput("rst_underrun", 32'(underrun), 32'd0);
        checkOutput("rst_count", 32'(underrun_count), 32'd0);
        reset = 1'b0;
        applyStimulus(1'b1);
        checkOutput("rel_ready", 32'(sample_ready), 32'd1);
        checkOutput("rel_underrun", 32'(underrun), 32'd0);
        checkOutput("rel_dacdat", 32'(dacdat), 32'd0);

        // Single sample through a 32-bclk frame.
        $display("[TB] single sample A5C3");
        pushSample(16'hA5C3, 1'b1);
        checkOutput("a5_level1", 32'(fifo_level), 32'd1);
        applyStimulus(1'b0);
        checkOutput("wait_fedge_dacdat", 32'(dacdat), 32'd0);
        applyStimulus(1'b0);
        runFrame(32, 16'hA5C3, 1'b0);
        checkOutput("a5_level0", 32'(fifo_level), 32'd0);

        // Fill the FIFO, offer a fifth, watch backpressure and ordering.
        $display("[TB] fifo fill and order");
        queued[0] = 16'h8421;
        queued[1] = 16'h7BDE;
        queued[2] = 16'h0F0F;
        queued[3] = 16'hC003;
        queued[4] = 16'h3C5A;
        for (int i = 0; i < 4; i++) begin
            pushSample(queued[i], 1'b0);
            checkOutput("fill_level", 32'(fifo_level), 32'(i + 1));
        end
        checkOutput("full_ready", 32'(sample_ready), 32'd0);
        pushSample(queued[4], 1'b0);
        checkOutput("full_level_hold", 32'(fifo_level), 32'd4);
        checkOutput("fifth_pending", 32'(sample_valid), 32'd1);
        runFrame(16, queued[0], 1'b0);
        checkOutput("fifth_accepted", 32'(sample_valid), 32'd0);
        checkOutput("refill_level", 32'(fifo_level), 32'd4);
        for (int i = 1; i < 5; i++) begin
            runFrame(16, queued[i], 1'b0);
        end
        checkOutput("drain_level", 32'(fifo_level), 32'd0);

        // Empty FIFO: silence and one underrun per left frame.
        $display("[TB] underruns");
        for (int i = 0; i < 3; i++) begin
            runFrame(16, 16'h0000, 1'b1);
        end
        checkOutput("ur_count3", 32'(underrun_count), 32'd3);
        force dut.underrun_count = 16'hFFFE;
        applyStimulus(1'b0);
        release dut.underrun_count;
        applyStimulus(1'b0);
        checkOutput("ur_preset", 32'(underrun_count), 32'hFFFE);
        runFrame(16, 16'h0000, 1'b1);
        checkOutput("ur_reach_max", 32'(underrun_count), 32'hFFFF);
        runFrame(16, 16'h0000, 1'b1);
        checkOutput("ur_saturate", 32'(underrun_count), 32'hFFFF);

        // Short 12-bclk half frames truncate; the following frame is clean.
        $display("[TB] short frames");
        pushSample(16'hFFFF, 1'b0);
        pushSample(16'h8001, 1'b0);
        runFrame(12, 16'hFFFF, 1'b0);
        runFrame(16, 16'h8001, 1'b0);
        checkOutput("short_level", 32'(fifo_level), 32'd0);

        // Reset in the middle of a left frame discards everything.
        $display("[TB] reset mid-frame");
        pushSample(16'h1234, 1'b0);
        pushSample(16'h5678, 1'b0);
        pushSample(16'h9ABC, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1);
        checkOutput("mid_level", 32'(fifo_level), 32'd2);
        checkOutput("mid_bit3", 32'(dacdat), 32'd1);
        reset = 1'b1;
        applyStimulus(1'b1);
        checkOutput("mid_rst_dacdat", 32'(dacdat), 32'd0);
        checkOutput("mid_rst_level", 32'(fifo_level), 32'd0);
        checkOutput("mid_rst_ready", 32'(sample_ready), 32'd0);
        checkOutput("mid_rst_count", 32'(underrun_count), 32'd0);
        reset = 1'b0;
        applyStimulus(1'b1);
        checkOutput("mid_rel_ready", 32'(sample_ready), 32'd1);
        checkOutput("mid_rel_underrun", 32'(underrun), 32'd0);
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        runFrame(16, 16'h0000, 1'b1);
        checkOutput("mid_post_count", 32'(underrun_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
